pixel_clkgen: RTL and testbench

Parametrised multi-channel pixel-clock generator for the GPU pixel pipeline. It replaces fixed-frequency PLL outputs with per-channel clock enables and divided clocks derived from one reference clock by phase accumulators. Each channel's ratio and phase is reprogrammable at runtime over a valid/ready configuration port, and a global `locked` flag is dropped and re-established after every reconfiguration. Downstream timing generators (video timing, rasteriser pacing) consume `clken` and gate their logic on `locked`.

---
 rtl/pixel_clkgen_pkg.sv | 19 +
 rtl/pixel_phase_acc.sv | 47 ++++
 rtl/pixel_clkgen.sv | 112 +++++++++++
 tb/tb_pixel_clkgen.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_clkgen_pkg.sv
// pixel_clkgen_pkg: shared types and helpers for the pixel clock generator.
//   state_t          - global control FSM state
//   ch_width(n)      - index width for n items, never below 1 bit
//   DEF_LOCK_CYCLES  - default settle time in refclk cycles
package pixel_clkgen_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_RUN    = 2'd1,
        ST_APPLY  = 2'd2
    } state_t;

    localparam int DEF_LOCK_CYCLES = 16;

    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_phase_acc.sv
// pixel_phase_acc: one channel of the pixel clock generator.
// A phase accumulator adds inc every cycle; the carry out is the clock
// enable, and outclk toggles on every cycle that carries.
//   refclk, rst_n          - clock, async active-low reset
//   load                   - synchronous load of load_inc / load_phase
//   load_inc, load_phase   - new increment and initial accumulator value
//   clken                  - registered carry of the accumulation
//   outclk                 - registered divided clock (f_clken / 2)
module pixel_phase_acc #(
    parameter int ACC_W = 24
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic [ACC_W-1:0] load_phase,
    output logic             clken,
    output logic             outclk
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;

    // One extra bit captures the carry out of the modulo-2^ACC_W add.
    assign sum = {1'b0, acc} + {1'b0, inc};

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            inc    <= '0;
            clken  <= 1'b0;
            outclk <= 1'b0;
        end else if (load) begin
            // Loading restarts the channel from a clean, low output.
            acc    <= load_phase;
            inc    <= load_inc;
            clken  <= 1'b0;
            outclk <= 1'b0;
        end else begin
            acc    <= sum[ACC_W-1:0];
            clken  <= sum[ACC_W];
            outclk <= outclk ^ sum[ACC_W];
        end
    end

endmodule

// File: rtl/pixel_clkgen.sv
// pixel_clkgen: multi-channel pixel clock generator built from phase
// accumulators, with a valid/ready port that reprograms one channel at a
// time and a global locked flag that re-settles after every change.
//   refclk, rst_n                   - clock, async active-low reset
//   cfg_valid, cfg_ready            - configuration handshake
//   cfg_chan, cfg_inc, cfg_phase    - target channel, increment, phase
//                                     (channel >= NUM_CH is ignored)
//   clken[NUM_CH]                   - per-channel enable pulses
//   outclk[NUM_CH]                  - per-channel divided clocks
//   locked                          - no reconfiguration for LOCK_CYCLES
module pixel_clkgen
    import pixel_clkgen_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int ACC_W       = 24,
    parameter  int LOCK_CYCLES = DEF_LOCK_CYCLES,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_chan,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] clken,
    output logic [NUM_CH-1:0] outclk,
    output logic              locked
);

    localparam int                CNT_W    = ch_width(LOCK_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] lock_cnt;
    logic             accept;

    logic [CH_W-1:0]  chan_q;
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] phase_q;

    assign cfg_ready = (state != ST_APPLY);
    assign accept    = cfg_valid && cfg_ready;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_SETTLE;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            case (state)
                ST_SETTLE: begin
                    // A new request wins over finishing the current settle.
                    if (accept) begin
                        state  <= ST_APPLY;
                        locked <= 1'b0;
                    end else if (lock_cnt == CNT_LAST) begin
                        state  <= ST_RUN;
                        locked <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        state  <= ST_APPLY;
                        locked <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    state    <= ST_SETTLE;
                    lock_cnt <= '0;
                end
                default: begin
                    state    <= ST_SETTLE;
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

    // Request fields are only consumed in APPLY, which always follows an
    // accept, so the latch itself needs no reset.
    always_ff @(posedge refclk) begin
        if (accept) begin
            chan_q  <= cfg_chan;
            inc_q   <= cfg_inc;
            phase_q <= cfg_phase;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic load;

        // Out-of-range channel numbers match no instance.
        assign load = (state == ST_APPLY) && (chan_q == CH_W'(i));

        pixel_phase_acc #(
            .ACC_W (ACC_W)
        ) u_acc (
            .refclk     (refclk),
            .rst_n      (rst_n),
            .load       (load),
            .load_inc   (inc_q),
            .load_phase (phase_q),
            .clken      (clken[i]),
            .outclk     (outclk[i])
        );
    end

endmodule

// File: tb/tb_pixel_clkgen.sv
// tb_pixel_clkgen: self-checking bench for pixel_clkgen. Three channels are
// instantiated so that cfg_chan = 3 is a genuinely out-of-range channel.
// The reference model describes each channel in closed form: after n
// accumulations from phase p with increment d, the number of carries is
// floor((p + n*d) / 2^ACC_W); clken is a change in that count and outclk is
// its parity. locked/cfg_ready follow from the edge numbers of accepts.
module tb_pixel_clkgen;

    localparam int NUM_CH = 3;
    localparam int ACC_W  = 8;
    localparam int LOCK   = 4;
    localparam int CH_W   = 2;

    logic              refclk = 1'b0;
    logic              rst_n  = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_chan  = '0;
    logic [ACC_W-1:0]  cfg_inc   = '0;
    logic [ACC_W-1:0]  cfg_phase = '0;
    logic [NUM_CH-1:0] clken;
    logic [NUM_CH-1:0] outclk;
    logic              locked;

    pixel_clkgen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .clken     (clken),
        .outclk    (outclk),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: edges are numbered from the reset release.
    longint cyc;
    longint m_phase [NUM_CH];
    longint m_inc   [NUM_CH];
    longint m_load  [NUM_CH];
    longint m_settle;
    longint m_acc_edge;
    int     p_chan;
    longint p_inc, p_phase;

    function automatic longint carries(int ch, longint n);
        return (m_phase[ch] + n * m_inc[ch]) >> ACC_W;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_clken();
        logic [NUM_CH-1:0] v;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            longint n;
            n = cyc - m_load[ch];
            v[ch] = (n >= 1) && (carries(ch, n) != carries(ch, n - 1));
        end
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_outclk();
        logic [NUM_CH-1:0] v;
        for (int ch = 0; ch < NUM_CH; ch++)
            v[ch] = carries(ch, cyc - m_load[ch]) % 2 == 1;
        return v;
    endfunction

    function automatic logic exp_ready();
        return cyc != m_acc_edge;
    endfunction

    function automatic logic exp_locked();
        return (cyc != m_acc_edge) && (cyc != m_acc_edge + 1) && (cyc - m_settle >= LOCK);
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_phase[ch] = 0;
            m_inc[ch]   = 0;
            m_load[ch]  = 0;
        end
        m_settle   = 0;
        m_acc_edge = -100;
    endtask

    // Advance one refclk edge and update the model; outputs are then
    // sampled 1 time unit after the edge.
    task automatic step();
        logic acc_now;
        acc_now = cfg_valid && exp_ready();
        @(posedge refclk);
        cyc++;
        if (cyc == m_acc_edge + 1) begin
            if (p_chan < NUM_CH) begin
                m_phase[p_chan] = p_phase;
                m_inc[p_chan]   = p_inc;
                m_load[p_chan]  = cyc;
            end
            m_settle = cyc;
        end
        if (acc_now) begin
            m_acc_edge = cyc;
            p_chan  = int'(cfg_chan);
            p_inc   = longint'(cfg_inc);
            p_phase = longint'(cfg_phase);
        end
        #1;
    endtask

    task automatic send(input int chan, input int inc, input int phase);
        cfg_valid = 1'b1;
        cfg_chan  = CH_W'(chan);
        cfg_inc   = ACC_W'(inc);
        cfg_phase = ACC_W'(phase);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        n_cmp++; if (clken !== '0) begin n_fail++; $display("FAIL reset_clken: got %b want 000", clken); end
        n_cmp++; if (outclk !== '0) begin n_fail++; $display("FAIL reset_outclk: got %b want 000", outclk); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
        release_reset();
        for (int i = 1; i <= 8; i++) begin
            step();
            n_cmp++; if (locked !== (i >= LOCK)) begin n_fail++; $display("FAIL reset_lock_edge%0d: got %b want %b", i, locked, i >= LOCK); end
            n_cmp++; if (clken !== '0) begin n_fail++; $display("FAIL reset_no_pulse: got %b want 000", clken); end
            n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        end
    endtask

    task automatic test_integer_divide();
        longint k;
        send(0, 64, 0);
        k = cyc;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL int_ready_apply: got %b want 0", cfg_ready); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL int_locked_drop: got %b want 0", locked); end
        for (int i = 1; i <= 24; i++) begin
            step();
            // Phase 0, inc 64: carries after edges k+5, k+9, ...; outclk high
            // for four cycles from each odd-numbered pulse.
            n_cmp++; if (clken[0] !== (i >= 5 && (i - 5) % 4 == 0)) begin n_fail++; $display("FAIL int_clken0 k+%0d: got %b", i, clken[0]); end
            n_cmp++; if (outclk[0] !== (i >= 5 && ((i - 5) / 4) % 2 == 0)) begin n_fail++; $display("FAIL int_outclk0 k+%0d: got %b", i, outclk[0]); end
            n_cmp++; if (locked !== (i >= 1 + LOCK)) begin n_fail++; $display("FAIL int_locked k+%0d: got %b", i, locked); end
            n_cmp++; if (clken !== exp_clken()) begin n_fail++; $display("FAIL int_model_clken: got %b want %b", clken, exp_clken()); end
        end
    endtask

    task automatic test_fractional_ratio();
        int cnt;
        send(1, 96, 0);
        repeat (6) step();
        for (int w = 0; w < 4; w++) begin
            cnt = 0;
            for (int i = 0; i < 8; i++) begin
                step();
                cnt += int'(clken[1]);
                n_cmp++; if (clken !== exp_clken()) begin n_fail++; $display("FAIL frac_clken: got %b want %b", clken, exp_clken()); end
                n_cmp++; if (outclk !== exp_outclk()) begin n_fail++; $display("FAIL frac_outclk: got %b want %b", outclk, exp_outclk()); end
            end
            n_cmp++; if (cnt != 3) begin n_fail++; $display("FAIL frac_window%0d: got %0d pulses want 3", w, cnt); end
        end
    endtask

    task automatic test_phase_preset();
        longint k;
        send(0, 64, 192);
        k = cyc;
        for (int i = 1; i <= 12; i++) begin
            step();
            // 192 + 64 carries on the very first accumulation at edge k+2.
            n_cmp++; if (clken[0] !== (i >= 2 && (i - 2) % 4 == 0)) begin n_fail++; $display("FAIL preset_clken0 k+%0d: got %b", i, clken[0]); end
            n_cmp++; if (clken !== exp_clken()) begin n_fail++; $display("FAIL preset_model: got %b want %b", clken, exp_clken()); end
        end
    endtask

    task automatic test_settle_reconfig();
        longint k1, k2;
        send(0, 64, 0);
        k1 = cyc;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL resettle_ready_k1: got %b want 0", cfg_ready); end
        step();
        n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL resettle_ready_k1p1: got %b want 1", cfg_ready); end
        send(1, 32, 16);
        k2 = cyc;
        n_cmp++; if (k2 != k1 + 2) begin n_fail++; $display("FAIL resettle_k2: got %0d want %0d", k2 - k1, 2); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL resettle_ready_k2: got %b want 0", cfg_ready); end
        for (int i = 1; i <= 8; i++) begin
            step();
            n_cmp++; if (locked !== (i >= 1 + LOCK)) begin n_fail++; $display("FAIL resettle_locked k2+%0d: got %b", i, locked); end
            n_cmp++; if (clken !== exp_clken()) begin n_fail++; $display("FAIL resettle_clken: got %b want %b", clken, exp_clken()); end
            n_cmp++; if (outclk !== exp_outclk()) begin n_fail++; $display("FAIL resettle_outclk: got %b want %b", outclk, exp_outclk()); end
        end
    endtask

    task automatic test_boundaries();
        int cnt;
        longint k;
        send(2, 255, 0);
        step();
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            cnt += int'(clken[2]);
            n_cmp++; if (clken !== exp_clken()) begin n_fail++; $display("FAIL bnd255_model: got %b want %b", clken, exp_clken()); end
        end
        n_cmp++; if (cnt != 255) begin n_fail++; $display("FAIL bnd255_count: got %0d want 255", cnt); end

        send(1, 0, 77);
        step();
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++; if (outclk[1] !== 1'b0 || clken[1] !== 1'b0) begin n_fail++; $display("FAIL bnd_inc0 freeze: got outclk %b clken %b want 0 0", outclk[1], clken[1]); end
        end

        send(3, 77, 5);
        k = cyc;
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL bnd_chan3_drop: got %b want 0", locked); end
        for (int i = 1; i <= 10; i++) begin
            step();
            n_cmp++; if (locked !== (i >= 1 + LOCK)) begin n_fail++; $display("FAIL bnd_chan3_locked k+%0d: got %b", i, locked); end
            n_cmp++; if (clken !== exp_clken()) begin n_fail++; $display("FAIL bnd_chan3_clken: got %b want %b", clken, exp_clken()); end
            n_cmp++; if (outclk !== exp_outclk()) begin n_fail++; $display("FAIL bnd_chan3_outclk: got %b want %b", outclk, exp_outclk()); end
        end
    endtask

    task automatic test_reset_mid_run();
        send(0, 255, 0);
        step();
        send(1, 128, 0);
        repeat (10) step();
        n_cmp++; if (locked !== 1'b1 || clken[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got locked %b clken0 %b want 1 1", locked, clken[0]); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (clken !== '0) begin n_fail++; $display("FAIL midrst_clken: got %b want 000", clken); end
        n_cmp++; if (outclk !== '0) begin n_fail++; $display("FAIL midrst_outclk: got %b want 000", outclk); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked: got %b want 0", locked); end
        @(posedge refclk);
        #1;
        release_reset();
        for (int i = 1; i <= 6; i++) begin
            step();
            n_cmp++; if (clken !== '0) begin n_fail++; $display("FAIL midrst_after_clken: got %b want 000", clken); end
            n_cmp++; if (locked !== exp_locked()) begin n_fail++; $display("FAIL midrst_after_locked: got %b want %b", locked, exp_locked()); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            cfg_valid = ($urandom_range(0, 15) == 0);
            cfg_chan  = CH_W'($urandom_range(0, 3));
            cfg_inc   = ACC_W'($urandom);
            cfg_phase = ACC_W'($urandom);
            step();
            n_cmp++; if (clken !== exp_clken()) begin n_fail++; $display("FAIL rand_clken @%0d: got %b want %b", cyc, clken, exp_clken()); end
            n_cmp++; if (outclk !== exp_outclk()) begin n_fail++; $display("FAIL rand_outclk @%0d: got %b want %b", cyc, outclk, exp_outclk()); end
            n_cmp++; if (locked !== exp_locked()) begin n_fail++; $display("FAIL rand_locked @%0d: got %b want %b", cyc, locked, exp_locked()); end
            n_cmp++; if (cfg_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready @%0d: got %b want %b", cyc, cfg_ready, exp_ready()); end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_integer_divide();
        test_fractional_ratio();
        test_phase_preset();
        test_settle_reconfig();
        test_boundaries();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
